instruction_encoder: RTL and testbench

Builds 32-bit micro-instructions (STORE, LOAD, GO) from host-side commands and a write-data stream, and issues them one at a time to the instruction decoder input over a valid/ready handshake. A STORE burst command expands into one STORE instruction per data word at consecutive addresses. LOAD and GO commands each produce a single instruction. The block sits between the host/DMA front end and the decoder, and is the only source of decoder instructions.

---
 rtl/instruction_encoder.sv | 123 ++++++++++++
 tb/tb_instruction_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Turns host commands plus a write-data stream into 32-bit STORE/LOAD/GO
// micro-instructions and issues them one at a time through a single output slot.
module instruction_encoder #(
  parameter int INSTR_WIDTH          = 32,
  parameter int WRITE_DATA_LENGTH    = 16,
  parameter int WRITE_ADDRESS_LENGTH = 14,
  parameter int READ_ADDRESS_LENGTH  = 14,
  parameter int LEN_WIDTH            = 15
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [1:0]                      cmd_op_i,
  input  logic [WRITE_ADDRESS_LENGTH-1:0] cmd_addr_i,
  input  logic [READ_ADDRESS_LENGTH-1:0]  cmd_end_addr_i,
  input  logic [LEN_WIDTH-1:0]            cmd_len_i,
  input  logic                            data_valid_i,
  output logic                            data_ready_o,
  input  logic [WRITE_DATA_LENGTH-1:0]    data_i,
  output logic [INSTR_WIDTH-1:0]          instr_o,
  output logic                            instr_valid_o,
  input  logic                            instr_ready_i,
  output logic                            busy_o,
  output logic                            err_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_STORE = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [WRITE_ADDRESS_LENGTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]            remain_q, remain_d;
  logic [INSTR_WIDTH-1:0]          instr_q, instr_d;
  logic                            valid_q, valid_d;
  logic                            err_q, err_d;

  logic slot_free;
  logic cmd_fire;
  logic data_fire;

  assign slot_free    = !valid_q || instr_ready_i;
  assign cmd_ready_o  = !rst_i && (state_q == S_IDLE) && slot_free;
  assign data_ready_o = !rst_i && (state_q == S_STORE) && slot_free;
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign data_fire    = data_valid_i && data_ready_o;

  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q != S_IDLE) || valid_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    instr_d  = instr_q;
    // a drain clears the slot unless something new loads on the same edge
    valid_d  = valid_q && !instr_ready_i;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          case (cmd_op_i)
            2'b00: begin
              if (cmd_len_i != '0) begin
                addr_d   = cmd_addr_i;
                remain_d = cmd_len_i;
                state_d  = S_STORE;
              end
            end
            2'b01: begin
              if (cmd_addr_i <= cmd_end_addr_i) begin
                instr_d = {2'b01, 1'b0, cmd_addr_i, 1'b0, cmd_end_addr_i};
                valid_d = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            2'b10: begin
              instr_d = {2'b10, {(INSTR_WIDTH-2){1'b0}}};
              valid_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_STORE: begin
        if (data_fire) begin
          instr_d  = {2'b00, addr_q, data_i};
          valid_d  = 1'b1;
          addr_d   = addr_q + WRITE_ADDRESS_LENGTH'(1);
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed scenarios plus random commands, all
// checked every cycle against a queue-based model of emitted instructions.
module tb_instruction_encoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [13:0] cmd_addr_i;
  logic [13:0] cmd_end_addr_i;
  logic [14:0] cmd_len_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [15:0] data_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        busy_o;
  logic        err_o;

  instruction_encoder dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op_i),
    .cmd_addr_i     (cmd_addr_i),
    .cmd_end_addr_i (cmd_end_addr_i),
    .cmd_len_i      (cmd_len_i),
    .data_valid_i   (data_valid_i),
    .data_ready_o   (data_ready_o),
    .data_i         (data_i),
    .instr_o        (instr_o),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // 0: ready low, 1: ready high, 2: random ready
  int ready_mode = 0;
  initial begin
    instr_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       instr_ready_i = 1'b0;
        1:       instr_ready_i = 1'b1;
        default: instr_ready_i = ($urandom % 3) != 0;
      endcase
    end
  end

  // Reference model: exp_q holds instructions emitted but not yet drained,
  // addr_q holds the addresses still owed by the open STORE burst.
  logic [31:0] exp_q[$];
  int          addr_q[$];
  logic [31:0] drain_log[$];
  int          drain_cnt = 0;
  bit          err_pend  = 1'b0;
  bit          sf_m, cmd_acc, data_acc;
  int          ad;

  always @(negedge clk_i) begin
    if (rst_i) begin
      check("rst_instr", instr_o, 32'h0);
      check("rst_valid", {31'b0, instr_valid_o}, 32'h0);
      check("rst_err", {31'b0, err_o}, 32'h0);
      check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'h0);
      check("rst_data_ready", {31'b0, data_ready_o}, 32'h0);
      exp_q.delete();
      addr_q.delete();
      err_pend = 1'b0;
    end else begin
      sf_m = (exp_q.size() == 0) || instr_ready_i;
      check("m_cmd_ready", {31'b0, cmd_ready_o}, {31'b0, (addr_q.size() == 0) && sf_m});
      check("m_data_ready", {31'b0, data_ready_o}, {31'b0, (addr_q.size() != 0) && sf_m});
      check("m_valid", {31'b0, instr_valid_o}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("m_instr", instr_o, exp_q[0]);
      check("m_err", {31'b0, err_o}, {31'b0, err_pend});
      check("m_busy", {31'b0, busy_o}, {31'b0, (exp_q.size() != 0) || (addr_q.size() != 0)});
      cmd_acc  = cmd_valid_i && (addr_q.size() == 0) && sf_m;
      data_acc = data_valid_i && (addr_q.size() != 0) && sf_m;
      if (exp_q.size() != 0 && instr_ready_i) begin
        drain_log.push_back(exp_q.pop_front());
        drain_cnt++;
      end
      err_pend = 1'b0;
      if (data_acc) begin
        ad = addr_q.pop_front();
        exp_q.push_back(32'((ad << 16) | int'(data_i)));
      end
      if (cmd_acc) begin
        case (cmd_op_i)
          2'd0: for (int i = 0; i < int'(cmd_len_i); i++) addr_q.push_back((int'(cmd_addr_i) + i) % 16384);
          2'd1: if (cmd_addr_i <= cmd_end_addr_i)
                  exp_q.push_back(32'h4000_0000 | 32'(int'(cmd_addr_i) << 15) | 32'(cmd_end_addr_i));
                else err_pend = 1'b1;
          2'd2: exp_q.push_back(32'h8000_0000);
          default: err_pend = 1'b1;
        endcase
      end
    end
  end

  logic [15:0] words_q[$];

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // called just after a rising edge; returns just after the handshake edge
  task automatic send_cmd(input logic [1:0] op, input int a, input int e, input int l);
    int k = 0;
    cmd_op_i       = op;
    cmd_addr_i     = a[13:0];
    cmd_end_addr_i = e[13:0];
    cmd_len_i      = l[14:0];
    cmd_valid_i    = 1'b1;
    @(negedge clk_i);
    while (!cmd_ready_o && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    if (!cmd_ready_o) check("cmd_timeout", {31'b0, cmd_ready_o}, 32'h1);
    sync();
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_words();
    int k;
    int gap;
    while (words_q.size() != 0) begin
      gap = $urandom % 3;
      repeat (gap) sync();
      data_i       = words_q.pop_front();
      data_valid_i = 1'b1;
      k = 0;
      @(negedge clk_i);
      while (!data_ready_o && k < 100) begin
        @(negedge clk_i);
        k++;
      end
      if (!data_ready_o) check("data_timeout", {31'b0, data_ready_o}, 32'h1);
      sync();
      data_valid_i = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk_i);
    while (busy_o && k < 500) begin
      @(negedge clk_i);
      k++;
    end
    #1;
    check("idle_timeout", {31'b0, busy_o}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  int n0;
  int rop, ra, re, rl;

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_end_addr_i = '0; cmd_len_i = '0;
    data_valid_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    check("reset_busy", {31'b0, busy_o}, 32'h0);
    sync();
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("post_reset_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);

    // LOAD 0x10..0x20 with free-running ready
    ready_mode = 1;
    sync(); sync();
    send_cmd(2'd1, 'h10, 'h20, 0);
    @(negedge clk_i); #1;
    check("load_instr", instr_o, 32'h4008_0020);
    check("load_valid", {31'b0, instr_valid_o}, 32'h1);
    @(negedge clk_i); #1;
    check("load_valid_one_cycle", {31'b0, instr_valid_o}, 32'h0);
    sync();

    // GO held while downstream stalls
    ready_mode = 0;
    sync(); sync();
    send_cmd(2'd2, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      check("go_hold_instr", instr_o, 32'h8000_0000);
      check("go_hold_cmd_ready", {31'b0, cmd_ready_o}, 32'h0);
    end
    ready_mode = 1;
    @(negedge clk_i); #1;
    check("go_drain_instr", instr_o, 32'h8000_0000);
    check("go_drain_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
    @(negedge clk_i); #1;
    check("go_drained_valid", {31'b0, instr_valid_o}, 32'h0);
    sync();

    // STORE burst across the address wrap, random gaps on both sides
    ready_mode = 2;
    sync();
    send_cmd(2'd0, 'h3FFE, 0, 3);
    words_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    send_words();
    wait_idle();
    check("wrap_word0", drain_log[drain_log.size()-3], 32'h3FFE_AAAA);
    check("wrap_word1", drain_log[drain_log.size()-2], 32'h3FFF_BBBB);
    check("wrap_word2", drain_log[drain_log.size()-1], 32'h0000_CCCC);
    check("wrap_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
    ready_mode = 1;
    sync(); sync();

    // illegal op, inverted LOAD range, empty STORE
    send_cmd(2'd3, 0, 0, 0);
    @(negedge clk_i); #1;
    check("op11_err", {31'b0, err_o}, 32'h1);
    check("op11_valid", {31'b0, instr_valid_o}, 32'h0);
    @(negedge clk_i); #1;
    check("op11_err_pulse", {31'b0, err_o}, 32'h0);
    sync();
    send_cmd(2'd1, 5, 4, 0);
    @(negedge clk_i); #1;
    check("badload_err", {31'b0, err_o}, 32'h1);
    check("badload_valid", {31'b0, instr_valid_o}, 32'h0);
    @(negedge clk_i); #1;
    check("badload_err_pulse", {31'b0, err_o}, 32'h0);
    sync();
    send_cmd(2'd0, 100, 0, 0);
    @(negedge clk_i); #1;
    check("len0_err", {31'b0, err_o}, 32'h0);
    check("len0_valid", {31'b0, instr_valid_o}, 32'h0);
    check("len0_busy", {31'b0, busy_o}, 32'h0);
    sync();

    // reset after two of five burst words
    send_cmd(2'd0, $urandom % 16384, 0, 5);
    words_q = '{16'h1111, 16'h2222};
    send_words();
    rst_i = 1'b1;
    #1;
    check("midrst_valid", {31'b0, instr_valid_o}, 32'h0);
    check("midrst_data_ready", {31'b0, data_ready_o}, 32'h0);
    check("midrst_busy", {31'b0, busy_o}, 32'h0);
    sync(); sync();
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("midrst_idle_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
    check("midrst_idle_busy", {31'b0, busy_o}, 32'h0);
    sync();
    send_cmd(2'd2, 0, 0, 0);
    @(negedge clk_i); #1;
    check("midrst_go_instr", instr_o, 32'h8000_0000);
    check("midrst_go_valid", {31'b0, instr_valid_o}, 32'h1);
    sync(); sync();

    // back-to-back GO at full rate
    n0 = drain_cnt;
    cmd_op_i    = 2'd2;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i); #1;
      check("b2b_cmd_ready", {31'b0, cmd_ready_o}, 32'h1);
      if (i > 0) check("b2b_valid", {31'b0, instr_valid_o}, 32'h1);
      sync();
    end
    cmd_valid_i = 1'b0;
    @(negedge clk_i); #1;
    check("b2b_last_valid", {31'b0, instr_valid_o}, 32'h1);
    sync();
    @(negedge clk_i); #1;
    check("b2b_end_valid", {31'b0, instr_valid_o}, 32'h0);
    check("b2b_count", 32'(drain_cnt - n0), 32'd8);
    sync();

    // random command mix under random backpressure
    ready_mode = 2;
    sync();
    for (int it = 0; it < 30; it++) begin
      rop = $urandom % 4;
      ra  = $urandom % 16384;
      re  = ($urandom % 2) ? (ra + $urandom % 64) % 16384 : $urandom % 16384;
      rl  = $urandom % 5;
      send_cmd(rop[1:0], ra, re, rl);
      if (rop == 0) begin
        for (int w = 0; w < rl; w++) words_q.push_back(16'($urandom));
        send_words();
      end
    end
    wait_idle();
    check("final_model_empty", 32'(exp_q.size() + addr_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
